// File: rtl/eth_rx_mac_filter.sv
// Destination-MAC filter on the 8-bit RX stream: buffers the 6 header bytes, decides, then replays them and passes the frame through.
// First header byte leaves one cycle after byte 5 is accepted; the input stalls for the 6 replay cycles and then follows m_axis_tready in PASS.
module eth_rx_mac_filter (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  s_axis_tdata,
  input  logic        s_axis_tvalid,
  output logic        s_axis_tready,
  input  logic        s_axis_tlast,
  input  logic        s_axis_tuser,
  output logic [7:0]  m_axis_tdata,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic        m_axis_tlast,
  output logic        m_axis_tuser,
  input  logic [47:0] mac_addr,
  input  logic        promiscuous,
  input  logic        accept_broadcast,
  input  logic        accept_multicast,
  output logic [31:0] frames_accepted,
  output logic [31:0] frames_dropped
);

  localparam logic [1:0] HDR   = 2'd0;
  localparam logic [1:0] FLUSH = 2'd1;
  localparam logic [1:0] PASS  = 2'd2;
  localparam logic [1:0] DROP  = 2'd3;

  logic [1:0]  state;
  logic [2:0]  idx;
  logic [7:0]  hdr_buf [0:5];
  logic        hdr_last;
  logic        hdr_user;
  logic [47:0] dest;
  logic        is_bcast;
  logic        is_mcast;
  logic        match;
  logic        s_hs;
  logic        m_hs;

  assign s_hs = s_axis_tvalid & s_axis_tready;
  assign m_hs = m_axis_tvalid & m_axis_tready;

  // Byte 5 is still on the input bus when the decision is taken.
  assign dest     = {hdr_buf[0], hdr_buf[1], hdr_buf[2], hdr_buf[3], hdr_buf[4], s_axis_tdata};
  assign is_bcast = &dest;
  assign is_mcast = dest[40] & ~is_bcast;
  assign match    = promiscuous | (dest == mac_addr) | (is_bcast & accept_broadcast)
                  | (is_mcast & accept_multicast);

  always_comb begin
    s_axis_tready = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = 8'd0;
    m_axis_tlast  = 1'b0;
    m_axis_tuser  = 1'b0;
    case (state)
      HDR, DROP: s_axis_tready = 1'b1;
      FLUSH: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = hdr_buf[idx];
        if (idx == 3'd5) begin
          m_axis_tlast = hdr_last;
          m_axis_tuser = hdr_user;
        end
      end
      PASS: begin
        s_axis_tready = m_axis_tready;
        m_axis_tvalid = s_axis_tvalid;
        m_axis_tdata  = s_axis_tdata;
        m_axis_tlast  = s_axis_tlast;
        m_axis_tuser  = s_axis_tuser;
      end
      default: ;
    endcase
    if (!reset_n) begin
      s_axis_tready = 1'b0;
      m_axis_tvalid = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (state == HDR && s_hs && idx <= 3'd5)
      hdr_buf[idx] <= s_axis_tdata;
  end

  // idx counts header bytes in HDR and replay position in FLUSH.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state           <= HDR;
      idx             <= 3'd0;
      hdr_last        <= 1'b0;
      hdr_user        <= 1'b0;
      frames_accepted <= 32'd0;
      frames_dropped  <= 32'd0;
    end else begin
      if (m_hs && m_axis_tlast)
        frames_accepted <= frames_accepted + 32'd1;
      case (state)
        HDR: begin
          if (s_hs) begin
            if (idx == 3'd5) begin
              idx      <= 3'd0;
              hdr_last <= s_axis_tlast;
              hdr_user <= s_axis_tuser;
              if (match)
                state <= FLUSH;
              else if (s_axis_tlast)
                frames_dropped <= frames_dropped + 32'd1;
              else
                state <= DROP;
            end else if (s_axis_tlast) begin
              idx            <= 3'd0;
              frames_dropped <= frames_dropped + 32'd1;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        FLUSH: begin
          if (m_hs) begin
            if (idx == 3'd5) begin
              idx   <= 3'd0;
              state <= hdr_last ? HDR : PASS;
            end else begin
              idx <= idx + 3'd1;
            end
          end
        end
        PASS: begin
          if (m_hs && m_axis_tlast)
            state <= HDR;
        end
        DROP: begin
          if (s_hs && s_axis_tlast) begin
            frames_dropped <= frames_dropped + 32'd1;
            state          <= HDR;
          end
        end
        default: state <= HDR;
      endcase
    end
  end

endmodule

// File: tb/tb_eth_rx_mac_filter.sv
// Scoreboard bench for eth_rx_mac_filter: frame-level reference model feeds an expected-beat queue checked by an output monitor.
module tb_eth_rx_mac_filter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [7:0]  s_axis_tdata;
  logic        s_axis_tvalid;
  logic        s_axis_tready;
  logic        s_axis_tlast;
  logic        s_axis_tuser;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;
  logic [47:0] mac_addr;
  logic        promiscuous;
  logic        accept_broadcast;
  logic        accept_multicast;
  logic [31:0] frames_accepted;
  logic [31:0] frames_dropped;

  always #4 clock = ~clock;

  eth_rx_mac_filter dut (
    .clock(clock), .reset_n(reset_n),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
    .mac_addr(mac_addr), .promiscuous(promiscuous), .accept_broadcast(accept_broadcast),
    .accept_multicast(accept_multicast),
    .frames_accepted(frames_accepted), .frames_dropped(frames_dropped)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  beat_t exp_q[$];
  logic [7:0] frm[$];
  int exp_acc = 0;
  int exp_drp = 0;
  bit bp = 0;

  int out_beats = 0;
  int first_out_cyc = 0;
  int beat6_cyc = 0;
  int b5_cyc = 0;
  int last_acc_cyc = 0;
  bit s_nr_seen = 0;

  always @(posedge clock) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, req);
    end
  endfunction

  initial begin
    m_axis_tready = 1'b1;
    forever begin
      @(posedge clock);
      #1;
      m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on every handshake, checks stall stability.
  bit    prev_stall = 0;
  beat_t prev_beat;
  beat_t cur_beat;
  beat_t exp_beat;
  always @(negedge clock) begin
    if (!reset_n) begin
      prev_stall = 0;
    end else begin
      if (!s_axis_tready) s_nr_seen = 1;
      if (prev_stall) chk("valid_hold", {31'd0, m_axis_tvalid}, 32'd1);
      if (m_axis_tvalid) begin
        cur_beat = '{d: m_axis_tdata, l: m_axis_tlast, u: m_axis_tuser};
        if (prev_stall) chk("data_hold", {22'd0, cur_beat}, {22'd0, prev_beat});
        if (m_axis_tready) begin
          if (out_beats == 0) first_out_cyc = cyc;
          if (out_beats == 6) beat6_cyc = cyc;
          out_beats++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h, expected no output", cur_beat);
          end else begin
            exp_beat = exp_q.pop_front();
            chk("out_beat", {22'd0, cur_beat}, {22'd0, exp_beat});
          end
          prev_stall = 0;
        end else begin
          prev_stall = 1;
          prev_beat  = cur_beat;
        end
      end else begin
        prev_stall = 0;
      end
    end
  end

  function automatic bit model_accept();
    logic [47:0] d;
    bit bc;
    if (frm.size() < 6) return 0;
    d  = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
    bc = (d == 48'hFFFF_FFFF_FFFF);
    return promiscuous || (d == mac_addr) || (bc && accept_broadcast)
        || (d[40] && !bc && accept_multicast);
  endfunction

  task automatic build_frame(input logic [47:0] dest, input int len);
    logic [47:0] t;
    frm.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 6) begin
        t = dest >> (8 * (5 - i));
        frm.push_back(t[7:0]);
      end else begin
        frm.push_back(8'($urandom()));
      end
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input logic l, input logic u);
    int t = 0;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    s_axis_tuser  = u;
    s_axis_tvalid = 1'b1;
    while (1) begin
      @(negedge clock);
      if (s_axis_tready) break;
      t++;
      if (t > 5000) begin
        checks++;
        errors++;
        $display("FAIL input_timeout: got tready=0 for %0d cycles, expected acceptance", t);
        break;
      end
    end
    last_acc_cyc = cyc;
    @(posedge clock);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_frame(input logic tuser, input bit gaps, input int stop_at);
    int len = frm.size();
    beat_t b;
    if (model_accept()) begin
      for (int i = 0; i < len; i++) begin
        b.d = frm[i];
        b.l = (i == len - 1);
        b.u = b.l & tuser;
        exp_q.push_back(b);
      end
      exp_acc++;
    end else begin
      exp_drp++;
    end
    for (int i = 0; i < len && i < stop_at; i++) begin
      if (gaps && $urandom_range(0, 7) == 0) begin
        @(posedge clock);
        #1;
      end
      push_byte(frm[i], i == len - 1, (i == len - 1) & tuser);
      if (i == 5) b5_cyc = last_acc_cyc;
    end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 20000) begin
      @(posedge clock);
      t++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending, expected 0", exp_q.size());
    end
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic check_counters(input string nm);
    chk({nm, "_accepted"}, frames_accepted, exp_acc);
    chk({nm, "_dropped"}, frames_dropped, exp_drp);
  endtask

  localparam logic [47:0] STATION = 48'h0200_0000_0001;

  initial begin
    logic [47:0] rd;
    int len;
    reset_n          = 1'b0;
    s_axis_tvalid    = 1'b0;
    s_axis_tdata     = 8'd0;
    s_axis_tlast     = 1'b0;
    s_axis_tuser     = 1'b0;
    mac_addr         = STATION;
    promiscuous      = 1'b0;
    accept_broadcast = 1'b0;
    accept_multicast = 1'b0;

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    chk("rst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    @(negedge clock);
    chk("rst_m_tdata", {24'd0, m_axis_tdata}, 32'd0);
    chk("rst_m_tlast", {31'd0, m_axis_tlast}, 32'd0);
    chk("rst_m_tuser", {31'd0, m_axis_tuser}, 32'd0);
    chk("idle_s_tready", {31'd0, s_axis_tready}, 32'd1);
    check_counters("rst");
    @(posedge clock);
    #1;

    // Unicast match with latency checks
    out_beats = 0;
    build_frame(STATION, 64);
    send_frame(1'b0, 1'b0, 64);
    wait_drain();
    chk("uni_beats", out_beats, 32'd64);
    chk("uni_first_lat", first_out_cyc - b5_cyc, 32'd1);
    chk("uni_pass_lat", beat6_cyc - b5_cyc, 32'd7);
    check_counters("uni");

    // Unicast miss
    out_beats = 0;
    s_nr_seen = 0;
    build_frame(48'h0200_0000_0002, 64);
    send_frame(1'b0, 1'b0, 64);
    wait_drain();
    chk("miss_beats", out_beats, 32'd0);
    chk("miss_tready_low", {31'd0, s_nr_seen}, 32'd0);
    check_counters("miss");

    // Broadcast rejected, then accepted; multicast accepted
    build_frame(48'hFFFF_FFFF_FFFF, 64);
    send_frame(1'b0, 1'b0, 64);
    wait_drain();
    check_counters("bc_off");
    accept_broadcast = 1'b1;
    build_frame(48'hFFFF_FFFF_FFFF, 64);
    send_frame(1'b0, 1'b0, 64);
    wait_drain();
    check_counters("bc_on");
    accept_multicast = 1'b1;
    build_frame(48'h0100_5E00_0001, 64);
    send_frame(1'b0, 1'b0, 64);
    wait_drain();
    check_counters("mc_on");

    // Runt and exact-6 frames
    out_beats = 0;
    build_frame(STATION, 4);
    send_frame(1'b0, 1'b0, 4);
    wait_drain();
    chk("runt_beats", out_beats, 32'd0);
    check_counters("runt");
    out_beats = 0;
    build_frame(STATION, 6);
    send_frame(1'b1, 1'b0, 6);
    wait_drain();
    chk("six_beats", out_beats, 32'd6);
    @(negedge clock);
    chk("six_back_to_hdr", {31'd0, s_axis_tready}, 32'd1);
    check_counters("six");
    @(posedge clock);
    #1;

    // Backpressure: 100 matching frames
    bp = 1;
    for (int f = 0; f < 100; f++) begin
      len = (f == 0) ? 60 : (f == 1) ? 1514 : $urandom_range(60, 300);
      build_frame(STATION, len);
      send_frame(1'($urandom_range(0, 1)), 1'b1, len);
    end
    wait_drain();
    check_counters("bp");

    // Randomised mix of destinations, configs and lengths (runts included)
    for (int f = 0; f < 40; f++) begin
      promiscuous      = ($urandom_range(0, 5) == 0);
      accept_broadcast = 1'($urandom_range(0, 1));
      accept_multicast = 1'($urandom_range(0, 1));
      rd[47:16] = $urandom();
      rd[15:0]  = 16'($urandom());
      case ($urandom_range(0, 4))
        0: rd = STATION;
        1: rd = STATION ^ 48'h1;
        2: rd = 48'hFFFF_FFFF_FFFF;
        3: rd[40] = 1'b1;
        default: rd[40] = 1'b0;
      endcase
      len = $urandom_range(1, 80);
      build_frame(rd, len);
      send_frame(1'($urandom_range(0, 1)), 1'b1, len);
    end
    wait_drain();
    check_counters("mix");
    bp               = 0;
    promiscuous      = 1'b0;
    accept_broadcast = 1'b0;
    accept_multicast = 1'b0;
    @(posedge clock);
    #1;

    // Reset during PASS, at byte 20 of a forwarded frame
    build_frame(STATION, 64);
    send_frame(1'b0, 1'b0, 20);
    reset_n = 1'b0;
    @(negedge clock);
    chk("midrst_m_tvalid", {31'd0, m_axis_tvalid}, 32'd0);
    chk("midrst_s_tready", {31'd0, s_axis_tready}, 32'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    exp_acc = 0;
    exp_drp = 0;
    @(negedge clock);
    check_counters("midrst");
    chk("midrst_m_tvalid_after", {31'd0, m_axis_tvalid}, 32'd0);
    @(posedge clock);
    #1;
    out_beats = 0;
    build_frame(STATION, 30);
    send_frame(1'b0, 1'b0, 30);
    wait_drain();
    chk("postrst_beats", out_beats, 32'd30);
    build_frame(48'h0200_0000_0003, 30);
    send_frame(1'b0, 1'b0, 30);
    wait_drain();
    check_counters("postrst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #720000;
    errors++;
    $display("FAIL watchdog: got no completion after 90000 cycles, expected finish");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
